// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine engine: one micro-rotation per cycle, one sample in flight.
// Optional macro CORDIC_ROUND_EN: round-half-up instead of truncation when dropping guard bits.
module cordic_sincos #(
  parameter int D_WIDTH = 16,
  parameter int ITERS   = 16,
  parameter int GUARD   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] theta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] sin,
  output logic [D_WIDTH-1:0] cos,
  output logic               busy
);

  localparam int XW = D_WIDTH + GUARD + 2;
  // z also carries GUARD fraction bits, so the atan table is in 2^-GUARD angle units
  localparam int ZW = D_WIDTH + 1 + GUARD;
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  function automatic int calc_k();
    real k, p;
    k = 1.0;
    p = 1.0;
    for (int i = 0; i < ITERS; i++) begin
      k = k / $sqrt(1.0 + p);
      p = p * 0.25;
    end
    return $rtoi(k * (2.0 ** (D_WIDTH - 1 + GUARD)) + 0.5);
  endfunction

  function automatic logic [ITERS*ZW-1:0] calc_atan();
    logic [ITERS*ZW-1:0] t;
    real p;
    t = '0;
    p = 1.0;
    for (int i = 0; i < ITERS; i++) begin
      t[i*ZW +: ZW] = ZW'($rtoi($atan(p) * (2.0 ** (D_WIDTH + GUARD)) / (2.0 * 3.14159265358979) + 0.5));
      p = p * 0.5;
    end
    return t;
  endfunction

  localparam logic signed [XW-1:0] X_INIT   = XW'(calc_k());
  localparam logic [ITERS*ZW-1:0]  ATAN_TAB = calc_atan();
  localparam logic signed [XW-1:0] HALF     = XW'((2 ** GUARD) / 2);
  localparam logic signed [XW-1:0] OMAX     = XW'((1 << (D_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] OMIN     = -OMAX - XW'(1);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t                 state, state_nxt;
  logic signed [XW-1:0]   x, y, x_nxt, y_nxt, x_sh, y_sh, c_pre, s_pre;
  logic signed [ZW-1:0]   z, z_nxt, atan_cur;
  logic [CW-1:0]          cnt;
  logic [1:0]             quad;

  function automatic logic [D_WIDTH-1:0] to_out(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] r;
`ifdef CORDIC_ROUND_EN
    r = (v + HALF) >>> GUARD;
`else
    r = v >>> GUARD;
`endif
    if (r > OMAX)      r = OMAX;
    else if (r < OMIN) r = OMIN;
    return r[D_WIDTH-1:0];
  endfunction

  always_comb begin
    atan_cur = ATAN_TAB[cnt*ZW +: ZW];
    x_sh     = x >>> cnt;
    y_sh     = y >>> cnt;
    if (!z[ZW-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_cur;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_cur;
    end
  end

  // Fold the first-quadrant result back to the full circle
  always_comb begin
    case (quad)
      2'd0:    begin c_pre = x;  s_pre = y;  end
      2'd1:    begin c_pre = -y; s_pre = x;  end
      2'd2:    begin c_pre = -x; s_pre = -y; end
      default: begin c_pre = y;  s_pre = -x; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ROT;
      end
      ROT:  if (cnt == LAST) state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      cnt       <= '0;
      quad      <= '0;
      sin       <= '0;
      cos       <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          quad <= theta[D_WIDTH-1:D_WIDTH-2];
          x    <= X_INIT;
          y    <= '0;
          z    <= ZW'({2'b00, theta[D_WIDTH-3:0]}) << GUARD;
          cnt  <= '0;
        end
        ROT: begin
          x   <= x_nxt;
          y   <= y_nxt;
          z   <= z_nxt;
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        DONE: begin
          // First DONE cycle registers the result; it then holds until consumed
          if (!out_valid) begin
            cos       <= to_out(c_pre);
            sin       <= to_out(s_pre);
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: reset, latency, quadrant vectors, backpressure, mid-op reset, random sweep.
module tb_cordic_sincos;
`ifdef CORDIC_ROUND_EN
  localparam int TOL = 2;
`else
  localparam int TOL = 4;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [15:0] theta = '0, sin_o, cos_o;
  int          checks = 0, errors = 0;
  int          s, c, lat, s0, c0;
  logic [15:0] t;

  cordic_sincos #(.D_WIDTH(16), .ITERS(16), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .theta(theta),
    .out_valid(out_valid), .out_ready(out_ready), .sin(sin_o), .cos(cos_o), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int got, input int exp);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    checks++;
    assert ((d <= TOL) === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d +/-%0d", tag, got, exp, TOL);
    end
  endtask

  function automatic int ideal(input real v);
    real r;
    int  q;
    r = v * 32768.0;
    q = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  // Present a sample, wait for the accept edge, then count edges until out_valid.
  task automatic do_sample(input logic [15:0] th, output int so, output int co, output int lo);
    int n;
    in_valid = 1'b1;
    theta    = th;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    theta    = 16'($urandom);
    lo = 0;
    while (!out_valid && lo < 40) begin @(posedge clk); #1; lo++; end
    chk($sformatf("out_valid_%04h", th), 32'(out_valid), 32'd1);
    so = int'($signed(sin_o));
    co = int'($signed(cos_o));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [15:0] vt [7] = '{16'h2000, 16'h4000, 16'h6000, 16'h8000, 16'hC000, 16'hFFFF, 16'h1000};
  int          vs [7] = '{23170, 32767, 23170, 0, -32768, -3, 12540};
  int          vc [7] = '{23170, 0, -23170, -32768, 0, 32767, 30274};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sin", 32'(sin_o), 32'd0);
    chk("rst_cos", 32'(cos_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_sample(16'h0000, s, c, lat);
    chk("latency", 32'(lat), 32'd17);
    chk("busy_done", 32'(busy), 32'd1);
    chk_near("cos_0000", c, 32767);
    chk_near("sin_0000", s, 0);
    release_out();

    for (int k = 0; k < 7; k++) begin
      do_sample(vt[k], s, c, lat);
      chk_near($sformatf("sin_%04h", vt[k]), s, vs[k]);
      chk_near($sformatf("cos_%04h", vt[k]), c, vc[k]);
      release_out();
    end

    // Backpressure with a pending in_valid that must not be consumed in DONE
    do_sample(16'h2000, s0, c0, lat);
    in_valid = 1'b1;
    theta    = 16'h4000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sin", 32'(int'($signed(sin_o))), 32'(s0));
      chk("bp_cos", 32'(int'($signed(cos_o))), 32'(c0));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    release_out();
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);
    do_sample(16'h4000, s, c, lat);
    chk_near("bp_next_sin", s, 32767);
    chk_near("bp_next_cos", c, 0);
    release_out();

    // Reset while iteration 5 is in progress
    in_valid = 1'b1;
    theta    = 16'h2000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_sin", 32'(sin_o), 32'd0);
    chk("mrst_cos", 32'(cos_o), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_sample(16'h1000, s, c, lat);
    chk("mrst_latency", 32'(lat), 32'd17);
    chk_near("mrst_sin_1000", s, 12540);
    chk_near("mrst_cos_1000", c, 30274);
    release_out();

    // Random sweep, back-to-back with out_ready held high
    out_ready = 1'b1;
    for (int k = 0; k < 150; k++) begin
      t = 16'($urandom_range(0, 65535));
      do_sample(t, s, c, lat);
      chk($sformatf("rnd_lat_%04h", t), 32'(lat), 32'd17);
      chk_near($sformatf("rnd_sin_%04h", t), s, ideal($sin(real'(t) * 2.0 * 3.14159265358979 / 65536.0)));
      chk_near($sformatf("rnd_cos_%04h", t), c, ideal($cos(real'(t) * 2.0 * 3.14159265358979 / 65536.0)));
    end
    out_ready = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
